// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the execute-stage ALU.
// Shifts (LSH/RSH/ASHR) exist only when ALU_SHIFT_EN is defined; see alu_unit.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDU = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBU = 5'd3;
    localparam logic [4:0] OP_CMP  = 5'd4;
    localparam logic [4:0] OP_CMPU = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_NOT  = 5'd9;
    localparam logic [4:0] OP_LSH  = 5'd10;
    localparam logic [4:0] OP_RSH  = 5'd11;
    localparam logic [4:0] OP_ASHR = 5'd12;
    localparam logic [4:0] OP_MOV  = 5'd13;
    localparam logic [4:0] OP_LUI  = 5'd14;
    localparam logic [4:0] OP_NOP  = 5'd31;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_L = 0;

    // True for every opcode that routes through the shared subtractor.
    function automatic logic is_sub_op(input logic [4:0] op);
        is_sub_op = (op == OP_SUB) || (op == OP_SUBU) ||
                    (op == OP_CMP) || (op == OP_CMPU);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Single shared WIDTH+1-bit adder/subtractor: subtraction is A + ~B + 1,
// so the raw carry-out is the inverse of borrow.
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             slt_o,
    output logic             ult_o
);

    logic [WIDTH:0]   raw_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cout_s;

    assign b_eff_s = b_i ^ {WIDTH{sub_i}};
    assign raw_s   = {1'b0, a_i} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_i};
    assign sum_o   = raw_s[WIDTH-1:0];
    assign cout_s  = raw_s[WIDTH];

    // For subtraction the reported flag is borrow, i.e. no carry-out.
    assign carry_o = sub_i ? ~cout_s : cout_s;
    assign ovf_o   = (a_i[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                     (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    assign slt_o   = sub_i & (sum_o[WIDTH-1] ^ ovf_o);
    assign ult_o   = sub_i & ~cout_s;

endmodule

// File: rtl/alu_unit.sv
// Registered ALU: result and {Z,C,F,N,L} flags one clock after the operands.
// Define ALU_SHIFT_EN to build LSH/RSH/ASHR; otherwise opcodes 10-12 act as NOP.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Opcode,
    output logic [WIDTH-1:0] C,
    output logic [4:0]       Flags
);

    logic [WIDTH-1:0] c_q, c_d;
    logic [4:0]       flags_q, flags_d;

    logic             sub_s;
    logic [WIDTH-1:0] as_sum_s;
    logic             as_carry_s, as_ovf_s, as_slt_s, as_ult_s;
    logic [WIDTH-1:0] lui_s;
    logic [WIDTH-1:0] res_s;
    logic             upd_s;
    logic             arith_s;

    assign sub_s = is_sub_op(Opcode);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i     (A),
        .b_i     (B),
        .sub_i   (sub_s),
        .sum_o   (as_sum_s),
        .carry_o (as_carry_s),
        .ovf_o   (as_ovf_s),
        .slt_o   (as_slt_s),
        .ult_o   (as_ult_s)
    );

    // Upper-immediate: B's low byte placed in the top byte of the word.
    always_comb begin
        lui_s = {WIDTH{1'b0}};
        lui_s[WIDTH-1 -: 8] = B[7:0];
    end

    // Result select; upd_s low means the outputs hold (NOP and unused codes).
    always_comb begin
        res_s   = c_q;
        upd_s   = 1'b0;
        arith_s = 1'b0;
        case (Opcode)
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_CMP, OP_CMPU: begin
                res_s   = as_sum_s;
                upd_s   = 1'b1;
                arith_s = 1'b1;
            end
            OP_AND: begin
                res_s = A & B;
                upd_s = 1'b1;
            end
            OP_OR: begin
                res_s = A | B;
                upd_s = 1'b1;
            end
            OP_XOR: begin
                res_s = A ^ B;
                upd_s = 1'b1;
            end
            OP_NOT: begin
                res_s = ~A;
                upd_s = 1'b1;
            end
`ifdef ALU_SHIFT_EN
            OP_LSH: begin
                res_s = A << B[3:0];
                upd_s = 1'b1;
            end
            OP_RSH: begin
                res_s = A >> B[3:0];
                upd_s = 1'b1;
            end
            OP_ASHR: begin
                res_s = $unsigned($signed(A) >>> B[3:0]);
                upd_s = 1'b1;
            end
`endif
            OP_MOV: begin
                res_s = B;
                upd_s = 1'b1;
            end
            OP_LUI: begin
                res_s = lui_s;
                upd_s = 1'b1;
            end
            default: begin
                res_s   = c_q;
                upd_s   = 1'b0;
                arith_s = 1'b0;
            end
        endcase
    end

    // Next-state: every updating opcode rewrites all five flags at once.
    always_comb begin
        c_d     = c_q;
        flags_d = flags_q;
        if (upd_s) begin
            c_d     = res_s;
            flags_d = 5'b00000;
            if ((Opcode == OP_CMP) || (Opcode == OP_CMPU)) begin
                flags_d[FLAG_Z] = (A == B);
                flags_d[FLAG_N] = as_slt_s;
                flags_d[FLAG_L] = as_ult_s;
            end else if (arith_s) begin
                flags_d[FLAG_Z] = (res_s == {WIDTH{1'b0}});
                flags_d[FLAG_C] = as_carry_s;
                flags_d[FLAG_F] = as_ovf_s & ((Opcode == OP_ADD) || (Opcode == OP_SUB));
                flags_d[FLAG_N] = res_s[WIDTH-1];
            end else begin
                flags_d[FLAG_Z] = (res_s == {WIDTH{1'b0}});
                flags_d[FLAG_N] = res_s[WIDTH-1];
            end
        end else begin
            c_d     = c_q;
            flags_d = flags_q;
        end
    end

    // Output registers, cleared asynchronously so in-flight results are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= {WIDTH{1'b0}};
            flags_q <= 5'b00000;
        end else begin
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

    assign C     = c_q;
    assign Flags = flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit (WIDTH=16): directed vectors plus random
// operations checked against an integer-arithmetic reference model.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a_s = 16'h0000;
    logic [15:0] b_s = 16'h0000;
    logic [4:0]  op_s = 5'd31;
    logic [15:0] c_s;
    logic [4:0]  flags_s;

    int checks = 0;
    int passed = 0;

    logic [15:0] mc = 16'h0000;
    logic [4:0]  mf = 5'b00000;

    alu_unit #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a_s),
        .B      (b_s),
        .Opcode (op_s),
        .C      (c_s),
        .Flags  (flags_s)
    );

    always #5 clk = ~clk;

    // Reference model written from the opcode rules with plain integer math.
    function automatic void ref_op(input logic [4:0] op, input logic [15:0] a,
                                   input logic [15:0] b,
                                   inout logic [15:0] c, inout logic [4:0] f);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int r = 0;
        int sh = ub % 16;
        bit upd = 1;
        bit z, cy, ov, n, l;
        logic [15:0] res;
        cy = 0; ov = 0; l = 0;
        case (op)
            5'd0, 5'd1: begin
                r = ua + ub; res = r[15:0]; cy = (r > 65535);
                ov = (op == 5'd0) && ((sa + sb) > 32767 || (sa + sb) < -32768);
            end
            5'd2, 5'd3: begin
                r = ua - ub; res = r[15:0]; cy = (ua < ub);
                ov = (op == 5'd2) && ((sa - sb) > 32767 || (sa - sb) < -32768);
            end
            5'd4, 5'd5: begin r = ua - ub; res = r[15:0]; end
            5'd6:  res = a & b;
            5'd7:  res = a | b;
            5'd8:  res = a ^ b;
            5'd9:  res = ~a;
`ifdef ALU_SHIFT_EN
            5'd10: begin r = ua << sh; res = r[15:0]; end
            5'd11: begin r = ua >> sh; res = r[15:0]; end
            5'd12: begin r = sa >>> sh; res = r[15:0]; end
`endif
            5'd13: res = b;
            5'd14: begin r = (ub % 256) * 256; res = r[15:0]; end
            default: begin upd = 0; res = c; end
        endcase
        z = (res == 16'h0000);
        n = res[15];
        if (op == 5'd4 || op == 5'd5) begin
            z = (ua == ub); n = (sa < sb); l = (ua < ub);
        end
        if (upd) begin
            c = res;
            f = {z, cy, ov, n, l};
        end
    endfunction

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: C observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: Flags observed %b expected %b", tag, obs, exp);
    endtask

    // Apply one operation, clock it, and compare with the model.
    task automatic step(input string tag, input logic [4:0] op,
                        input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        op_s = op; a_s = a; b_s = b;
        @(posedge clk);
        #1;
        ref_op(op, a, b, mc, mf);
        chk16(tag, c_s, mc);
        chk5(tag, flags_s, mf);
    endtask

    initial begin
        logic [15:0] hold_c;
        logic [4:0]  hold_f;
        #12;
        chk16("reset_c", c_s, 16'h0000);
        chk5("reset_f", flags_s, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk16("post_release_c", c_s, 16'h0000);
        chk5("post_release_f", flags_s, 5'b00000);

        step("add_ovf", 5'd0, 16'h7FFF, 16'h0001);
        chk16("add_ovf_k", c_s, 16'h8000); chk5("add_ovf_k", flags_s, 5'b00110);
        step("addu_wrap", 5'd1, 16'hFFFF, 16'h0001);
        chk16("addu_wrap_k", c_s, 16'h0000); chk5("addu_wrap_k", flags_s, 5'b11000);
        step("sub_ovf", 5'd2, 16'h8000, 16'h0001);
        chk16("sub_ovf_k", c_s, 16'h7FFF); chk5("sub_ovf_k", flags_s, 5'b00100);
        step("sub_borrow", 5'd2, 16'h0000, 16'h0001);
        chk16("sub_borrow_k", c_s, 16'hFFFF); chk5("sub_borrow_k", flags_s, 5'b01010);
        step("cmp_neg", 5'd4, 16'hFFFE, 16'h0001);
        chk5("cmp_neg_k", flags_s, 5'b00010);
        step("cmpu_lt", 5'd5, 16'h0001, 16'hFFFF);
        chk5("cmpu_lt_k", flags_s, 5'b00001);
        step("cmp_eq", 5'd4, 16'h1234, 16'h1234);
        chk5("cmp_eq_k", flags_s, 5'b10000);
        step("lui", 5'd14, 16'h0000, 16'h12AB);
        chk16("lui_k", c_s, 16'hAB00);
        step("mov", 5'd13, 16'h5555, 16'h8001);

        hold_c = c_s; hold_f = flags_s;
        step("nop_hold", 5'd31, 16'hDEAD, 16'hBEEF);
        chk16("nop_hold_k", c_s, hold_c); chk5("nop_hold_k", flags_s, hold_f);
        step("unused_hold", 5'd20, 16'h0000, 16'h0000);
        chk16("unused_hold_k", c_s, hold_c);

`ifdef ALU_SHIFT_EN
        step("lsh", 5'd10, 16'h0001, 16'h000F);
        chk16("lsh_k", c_s, 16'h8000); chk5("lsh_k", flags_s, 5'b00010);
        step("ashr", 5'd12, 16'h8000, 16'h0004);
        chk16("ashr_k", c_s, 16'hF800);
`else
        step("shift_off_hold", 5'd10, 16'h0001, 16'h000F);
        chk16("shift_off_hold_k", c_s, hold_c);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [4:0] rop;
            rop = (i % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 14));
            step("random", rop, 16'($urandom), 16'($urandom));
        end

        step("pre_reset", 5'd13, 16'h0000, 16'hA5A5);
        @(negedge clk);
        op_s = 5'd0; a_s = 16'h1111; b_s = 16'h2222;
        #2;
        rst_n = 1'b0;
        #1;
        chk16("mid_reset_c", c_s, 16'h0000);
        chk5("mid_reset_f", flags_s, 5'b00000);
        @(posedge clk);
        #1;
        chk16("reset_held_c", c_s, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        mc = 16'h0000; mf = 5'b00000;
        step("after_reset", 5'd2, 16'h0005, 16'h0007);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
